// File: rtl/cnt_seq_ctrl.sv
// Programmable 16-bit down-counter with reload, one-shot/periodic modes,
// terminal-count pulse, sticky pending flag and a small 4-entry register map.
module cnt_seq_ctrl (
    input  logic       MasterClock,
    input  logic       RESET,
    input  logic       CE,
    input  logic       WR,
    input  logic       RD,
    input  logic [1:0] ADDR,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    output logic       TC,
    output logic       INT,
    output logic       RUN
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT} state_t;

    state_t      state_q;
    logic [15:0] reload_q;
    logic [15:0] count_q;
    logic [7:0]  snap_q;
    logic        en_q;
    logic        mode_q;
    logic        inten_q;
    logic        pend_q;

    logic ctrl_wr;
    logic stop_wr;
    logic start_wr;
    logic pend_clr;
    logic snap_rd;
    logic at_term;
    logic tc_d;

    assign ctrl_wr  = WR && (ADDR == 2'd2);
    assign stop_wr  = ctrl_wr && !DIN[0];
    assign start_wr = ctrl_wr && DIN[0] && DIN[7];
    assign pend_clr = WR && (ADDR == 2'd3) && DIN[0];
    assign snap_rd  = RD && (ADDR == 2'd0);
    assign at_term  = (state_q == S_COUNT) && CE && (count_q == 16'd0);
    // A disabling CTRL write or reset swallows the terminal count; a START does not.
    assign tc_d     = !RESET && at_term && !stop_wr;

    always_ff @(posedge MasterClock) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            reload_q <= 16'd0;
            count_q  <= 16'd0;
            snap_q   <= 8'd0;
            en_q     <= 1'b0;
            mode_q   <= 1'b0;
            inten_q  <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            if (WR && (ADDR == 2'd0)) reload_q[7:0]  <= DIN;
            if (WR && (ADDR == 2'd1)) reload_q[15:8] <= DIN;
            if (ctrl_wr) {inten_q, mode_q, en_q} <= DIN[2:0];
            if (snap_rd) snap_q <= count_q[15:8];

            if (tc_d)          pend_q <= 1'b1;
            else if (pend_clr) pend_q <= 1'b0;

            if (stop_wr) begin
                state_q <= S_IDLE;
            end else if (start_wr) begin
                state_q <= S_LOAD;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        count_q <= reload_q;
                        state_q <= S_COUNT;
                    end
                    S_COUNT: begin
                        if (CE) begin
                            if (count_q != 16'd0) count_q <= count_q - 16'd1;
                            else if (mode_q)      count_q <= reload_q;
                            else                  state_q <= S_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign TC  = tc_d;
    assign RUN = !RESET && (state_q != S_IDLE);
    assign INT = !RESET && pend_q && inten_q;

    always_comb begin
        DOUT = 8'h00;
        if (!RESET) begin
            case (ADDR)
                2'd0:    DOUT = count_q[7:0];
                2'd1:    DOUT = snap_q;
                2'd2:    DOUT = {5'd0, inten_q, mode_q, en_q};
                default: DOUT = {6'd0, (state_q != S_IDLE), pend_q};
            endcase
        end
    end
endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl: a cycle model checks every output each
// cycle, and literal expectations pin the key scenarios.
module tb_cnt_seq_ctrl;
    logic       MasterClock;
    logic       RESET;
    logic       CE;
    logic       WR;
    logic       RD;
    logic [1:0] ADDR;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       TC;
    logic       INT;
    logic       RUN;

    int nchk  = 0;
    int nfail = 0;

    cnt_seq_ctrl dut (
        .MasterClock(MasterClock),
        .RESET(RESET),
        .CE(CE),
        .WR(WR),
        .RD(RD),
        .ADDR(ADDR),
        .DIN(DIN),
        .DOUT(DOUT),
        .TC(TC),
        .INT(INT),
        .RUN(RUN)
    );

    initial begin
        MasterClock = 1'b0;
        forever #5 MasterClock = ~MasterClock;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks whether a run is active, whether the reload
    // is still to be applied, and the remaining tick count.
    logic [15:0] m_count  = 16'd0;
    logic [15:0] m_reload = 16'd0;
    logic [7:0]  m_snap   = 8'd0;
    bit m_active = 0, m_fresh = 0, m_en = 0, m_mode = 0, m_inten = 0, m_pend = 0;

    always @(negedge MasterClock) begin : model
        logic        e_tc;
        logic [7:0]  e_dout;
        logic        tstop;
        logic        tstart;
        logic [15:0] o_count;
        logic [15:0] o_reload;
        bit          o_mode;
        tstop  = WR && (ADDR == 2'd2) && !DIN[0];
        tstart = WR && (ADDR == 2'd2) && DIN[0] && DIN[7];
        e_tc   = !RESET && m_active && !m_fresh && CE && (m_count == 16'd0) && !tstop;
        case (ADDR)
            2'd0:    e_dout = m_count[7:0];
            2'd1:    e_dout = m_snap;
            2'd2:    e_dout = {5'd0, m_inten, m_mode, m_en};
            default: e_dout = {6'd0, m_active, m_pend};
        endcase
        if (RESET) e_dout = 8'h00;
        chk("m_tc",   16'(TC),   16'(e_tc));
        chk("m_run",  16'(RUN),  16'(!RESET && m_active));
        chk("m_int",  16'(INT),  16'(!RESET && m_pend && m_inten));
        chk("m_dout", 16'(DOUT), 16'(e_dout));

        if (RESET) begin
            m_count = 16'd0; m_reload = 16'd0; m_snap = 8'd0;
            m_active = 0; m_fresh = 0; m_en = 0; m_mode = 0; m_inten = 0; m_pend = 0;
        end else begin
            o_count = m_count; o_reload = m_reload; o_mode = m_mode;
            if (WR && ADDR == 2'd0) m_reload[7:0]  = DIN;
            if (WR && ADDR == 2'd1) m_reload[15:8] = DIN;
            if (WR && ADDR == 2'd2) {m_inten, m_mode, m_en} = DIN[2:0];
            if (RD && ADDR == 2'd0) m_snap = o_count[15:8];
            if (e_tc) m_pend = 1;
            else if (WR && ADDR == 2'd3 && DIN[0]) m_pend = 0;
            if (tstop) m_active = 0;
            else if (tstart) begin m_active = 1; m_fresh = 1; end
            else if (m_active && m_fresh) begin m_count = o_reload; m_fresh = 0; end
            else if (m_active && CE) begin
                if (o_count != 16'd0) m_count = o_count - 16'd1;
                else if (o_mode)      m_count = o_reload;
                else                  m_active = 0;
            end
        end
    end

    // Inputs change 1ns after the rising edge; returns at the falling edge so
    // the caller can check the outputs for this cycle.
    task automatic tick(input logic rst, input logic ce, input logic wr, input logic rd,
                        input logic [1:0] a, input logic [7:0] d);
        @(posedge MasterClock);
        #1;
        RESET = rst; CE = ce; WR = wr; RD = rd; ADDR = a; DIN = d;
        @(negedge MasterClock);
    endtask

    initial begin
        int tc_seen;
        int last_tc;
        RESET = 1'b1; CE = 1'b0; WR = 1'b0; RD = 1'b0; ADDR = 2'd0; DIN = 8'h00;

        // Reset, including reset overriding a concurrent write
        tick(1, 0, 0, 0, 0, 8'h00);
        tick(1, 1, 1, 0, 2, 8'h85);
        chk("rst_run", 16'(RUN), 16'd0);
        for (int a = 0; a < 4; a++) begin
            tick(0, 0, 0, 0, 2'(a), 8'h00);
            chk("rst_dout", 16'(DOUT), 16'h00);
        end

        // One-shot, RELOAD=3, INTEN
        tick(0, 0, 1, 0, 0, 8'h03);
        tick(0, 0, 1, 0, 1, 8'h00);
        tick(0, 0, 1, 0, 2, 8'h85);
        tick(0, 1, 0, 0, 2, 8'h00);
        chk("os_ctrl_rd", 16'(DOUT), 16'h05);
        chk("os_run_load", 16'(RUN), 16'd1);
        for (int k = 0; k < 3; k++) begin
            tick(0, 1, 0, 0, 0, 8'h00);
            chk("os_cnt", 16'(DOUT), 16'(3 - k));
            chk("os_no_tc", 16'(TC), 16'd0);
        end
        tick(0, 1, 0, 0, 0, 8'h00);
        chk("os_tc", 16'(TC), 16'd1);
        tick(0, 1, 0, 0, 3, 8'h00);
        chk("os_run_fall", 16'(RUN), 16'd0);
        chk("os_int", 16'(INT), 16'd1);
        chk("os_status", 16'(DOUT), 16'h01);
        tick(0, 0, 0, 0, 0, 8'h00);
        chk("os_count0", 16'(DOUT), 16'h00);
        tick(0, 0, 1, 0, 3, 8'h01);
        tick(0, 0, 0, 0, 3, 8'h00);
        chk("os_pend_clr", 16'(DOUT), 16'h00);

        // Periodic, RELOAD=2, CE every 3rd cycle, INTEN=0
        tick(0, 0, 1, 0, 0, 8'h02);
        tick(0, 0, 1, 0, 2, 8'h83);
        tc_seen = 0;
        last_tc = 0;
        for (int i = 0; i < 36; i++) begin
            tick(0, (i % 3) == 2, 0, 0, 3, 8'h00);
            if (TC) begin
                if (tc_seen > 0) chk("per_spacing", 16'(i - last_tc), 16'd9);
                tc_seen++;
                last_tc = i;
            end
        end
        chk("per_tc_count", 16'(tc_seen), 16'd4);
        tick(0, 0, 0, 0, 3, 8'h00);
        chk("per_status", 16'(DOUT), 16'h03);
        chk("per_int", 16'(INT), 16'd0);
        tick(0, 0, 1, 0, 2, 8'h00);
        tick(0, 0, 1, 0, 3, 8'h01);

        // Coherent 16-bit read across 0x0100
        tick(0, 0, 1, 0, 0, 8'h01);
        tick(0, 0, 1, 0, 1, 8'h01);
        tick(0, 0, 1, 0, 2, 8'h81);
        tick(0, 1, 0, 0, 0, 8'h00);
        tick(0, 1, 0, 0, 0, 8'h00);
        tick(0, 1, 0, 1, 0, 8'h00);
        chk("coh_lo", 16'(DOUT), 16'h00);
        tick(0, 1, 0, 0, 1, 8'h00);
        tick(0, 1, 0, 1, 1, 8'h00);
        chk("coh_hi", 16'(DOUT), 16'h01);
        tick(0, 0, 1, 0, 2, 8'h00);

        // Set beats clear on the terminal-count cycle
        tick(0, 0, 1, 0, 0, 8'h01);
        tick(0, 0, 1, 0, 1, 8'h00);
        tick(0, 0, 1, 0, 2, 8'h85);
        tick(0, 1, 0, 0, 0, 8'h00);
        tick(0, 1, 0, 0, 0, 8'h00);
        tick(0, 1, 1, 0, 3, 8'h01);
        chk("sbc_tc", 16'(TC), 16'd1);
        tick(0, 0, 0, 0, 3, 8'h00);
        chk("sbc_pend", 16'(DOUT), 16'h01);
        chk("sbc_int", 16'(INT), 16'd1);
        tick(0, 0, 1, 0, 3, 8'h01);
        tick(0, 0, 1, 0, 2, 8'h00);

        // Abort mid-count, then restart with a new reload
        tick(0, 0, 1, 0, 0, 8'h08);
        tick(0, 0, 1, 0, 2, 8'h81);
        tick(0, 1, 0, 0, 0, 8'h00);
        for (int k = 0; k < 3; k++) tick(0, 1, 0, 0, 0, 8'h00);
        tick(0, 1, 1, 0, 2, 8'h00);
        chk("abort_no_tc", 16'(TC), 16'd0);
        tick(0, 1, 0, 0, 0, 8'h00);
        chk("abort_hold", 16'(DOUT), 16'h05);
        chk("abort_idle", 16'(RUN), 16'd0);
        tick(0, 1, 0, 0, 0, 8'h00);
        chk("abort_hold2", 16'(DOUT), 16'h05);
        tick(0, 0, 1, 0, 0, 8'h20);
        tick(0, 1, 1, 0, 2, 8'h83);
        tick(0, 1, 0, 0, 0, 8'h00);
        chk("restart_load", 16'(RUN), 16'd1);
        tick(0, 0, 0, 0, 0, 8'h00);
        chk("restart_cnt", 16'(DOUT), 16'h20);

        // RELOAD write during COUNT leaves COUNT alone; START with TC
        tick(0, 0, 1, 0, 0, 8'h00);
        tick(0, 0, 0, 0, 0, 8'h00);
        chk("reload_nochg", 16'(DOUT), 16'h20);
        tick(0, 0, 1, 0, 2, 8'h83);
        tick(0, 0, 0, 0, 0, 8'h00);
        tick(0, 1, 0, 0, 0, 8'h00);
        chk("p0_tc", 16'(TC), 16'd1);
        tick(0, 1, 1, 0, 2, 8'h83);
        chk("start_tc", 16'(TC), 16'd1);
        tick(0, 1, 0, 0, 3, 8'h00);
        chk("load_ce_ign", 16'(TC), 16'd0);
        chk("start_status", 16'(DOUT), 16'h03);
        tick(0, 0, 1, 0, 2, 8'h00);
        tick(0, 0, 1, 0, 3, 8'h01);

        // Reset mid-count with CE and a write active
        tick(0, 0, 1, 0, 0, 8'h03);
        tick(0, 0, 1, 0, 2, 8'h85);
        tick(0, 1, 0, 0, 0, 8'h00);
        tick(0, 1, 0, 0, 0, 8'h00);
        tick(0, 1, 0, 0, 0, 8'h00);
        chk("mid_cnt", 16'(DOUT), 16'h02);
        tick(0, 1, 0, 0, 0, 8'h00);
        chk("mid_cnt1", 16'(DOUT), 16'h01);
        tick(1, 1, 1, 1, 3, 8'h01);
        chk("mid_rst_tc", 16'(TC), 16'd0);
        chk("mid_rst_dout", 16'(DOUT), 16'h00);
        for (int a = 0; a < 4; a++) begin
            tick(0, 1, 0, 0, 2'(a), 8'h00);
            chk("post_rst_dout", 16'(DOUT), 16'h00);
            chk("post_rst_run", 16'(RUN), 16'd0);
        end
        chk("post_rst_int", 16'(INT), 16'd0);

        tick(0, 0, 0, 0, 0, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/cnt_seq_ctrl.md
CNT_SEQ_CTRL -- requirements
Module: cnt_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port `MasterClock`: input, 1 bit, the only clock; all state updates on its rising edge.
REQ-003 Port `RESET`: input, 1 bit, synchronous active-high reset, sampled on the `MasterClock` edge.
REQ-004 Port `CE`: input, 1 bit, count-tick enable, one `MasterClock` cycle wide; counting advances only on cycles with `CE`=1.
REQ-005 Port `WR`: input, 1 bit, register write strobe, one cycle per write.
REQ-006 Port `RD`: input, 1 bit, register read strobe, used only for read-side snapshot effects.
REQ-007 Port `ADDR`: input, 2 bits, register select.
REQ-008 Port `DIN`: input, 8 bits, write data.
REQ-009 Port `DOUT`: output, 8 bits, read data; combinational from `ADDR` and register state.
REQ-010 Port `TC`: output, 1 bit, terminal-count pulse, one cycle wide.
REQ-011 Port `INT`: output, 1 bit, level interrupt; equals pending AND INTEN.
REQ-012 Port `RUN`: output, 1 bit, high while the state is LOAD or COUNT.

Function
REQ-013 The register map SHALL be as follows.
- Address 0: write sets RELOAD[7:0]; read returns COUNT[7:0].
- Address 1: write sets RELOAD[15:8]; read returns SNAP.
- Address 2: CTRL. Bit0 EN, bit1 MODE (1 = periodic, 0 = one-shot), bit2 INTEN, bits6:3 read as 0. Bit7 START is write-only, self-clearing, and reads as 0.
- Address 3: STATUS. Bit0 PEND, bit1 RUN, other bits 0. Writing 1 to bit0 clears PEND.
REQ-014 A cycle with `RD`=1 and `ADDR`=0 SHALL copy COUNT[15:8] into the 8-bit SNAP register, so a low-then-high read returns a coherent 16-bit value.
REQ-015 The block SHALL implement a state machine with states IDLE, LOAD and COUNT.
REQ-016 IDLE: a CTRL write with bit7=1 and bit0=1 SHALL move to LOAD; all other cases stay in IDLE and COUNT holds.
REQ-017 LOAD: COUNT SHALL take RELOAD and the state SHALL move to COUNT unconditionally after one cycle, regardless of `CE`.
REQ-018 COUNT with `CE`=1 and COUNT≠0: COUNT SHALL decrement by 1, modulo 16 bits with no wrap past 0.
REQ-019 COUNT with `CE`=1 and COUNT=0: `TC`=1 for that cycle and PEND SHALL be set.
- MODE=1 (periodic): COUNT takes RELOAD and the state stays in COUNT.
- MODE=0 (one-shot): the state moves to IDLE and COUNT holds at 0.
REQ-020 The period SHALL be RELOAD+1 `CE` ticks; RELOAD=0 in periodic mode gives `TC` on every `CE` tick.
REQ-021 A CTRL write with bit0=0 SHALL force IDLE on the next cycle from any state, with COUNT frozen and no `TC`.
REQ-022 A START write while in LOAD or COUNT SHALL restart the sequence by going to LOAD; no `TC` is produced for the abandoned count.
REQ-023 A RELOAD write during COUNT SHALL not alter COUNT; the new value takes effect at the next LOAD or periodic reload.
REQ-024 If a PEND set (from terminal count) and a PEND clear write occur in the same cycle, the set SHALL win.
REQ-025 A START write in the same cycle as a terminal count SHALL give priority to START: next state LOAD, and `TC`/PEND still assert for that cycle.
REQ-026 `CE` asserted during LOAD SHALL be ignored, with no decrement.
REQ-027 Register writes SHALL take effect on the clock edge; reads SHALL reflect the pre-edge register values.

Reset
REQ-028 `RESET`=1 at a clock edge SHALL force state IDLE and clear to 0: RELOAD, COUNT, SNAP, EN, MODE, INTEN and PEND.
REQ-029 During and immediately after reset, outputs SHALL be `TC`=0, `INT`=0, `RUN`=0, and `DOUT`=0x00 for all addresses.
REQ-030 `RESET` SHALL override any concurrent `WR`, `RD` or `CE` activity, including when it is asserted in the middle of a count; no `TC` occurs in that cycle.

Verification
REQ-031 One-shot: RELOAD=0x0003, CTRL=0x85, `CE` held at 1 → `TC` once on the 4th COUNT-state `CE` cycle; `RUN` falls the next cycle; PEND=1; `INT`=1; COUNT=0.
REQ-032 Periodic with gapped CE: RELOAD=0x0002, CTRL=0x83, `CE` every 3rd cycle → `TC` every 3 `CE` ticks (every 9 clocks) for 4 periods; `INT`=0 because INTEN=0.
REQ-033 Coherent read: COUNT=0x0100 when counting at full `CE` → `RD` address 0 returns 0x00, then `RD` address 1 two cycles later returns 0x01 (SNAP), not 0x00.
REQ-034 Set-beats-clear: write STATUS=0x01 on the same cycle as `TC` → PEND=1 afterwards and `INT` stays 1.
REQ-035 Abort and restart: CTRL=0x00 mid-count (COUNT=0x0005) → IDLE with COUNT held at 0x0005 and no `TC`; then CTRL=0x83 → LOAD, and COUNT equals RELOAD one cycle later.
REQ-036 Reset mid-count: assert `RESET` while COUNT=0x0001 and `CE`=1 → no `TC`; all registers 0; `DOUT` reads 0x00 at every address.
